// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring sequence checker.
// The helpers work on a MAX_W-bit word; callers zero-extend narrower rings.
package ring_pkg;

    localparam int unsigned MAX_W  = 16;
    localparam int unsigned MAX_IW = 4;

    typedef enum logic [1:0] {
        HUNT,
        TRACK,
        LOCK
    } ring_state_e;

    // Exactly one bit set; all-zero and multi-hot words are illegal.
    function automatic logic is_onehot(input logic [MAX_W-1:0] w);
        return ($countones(w) == 1);
    endfunction

    // Binary position of the hot bit (only meaningful for a one-hot word).
    function automatic logic [MAX_IW-1:0] onehot2bin(input logic [MAX_W-1:0] w);
        logic [MAX_IW-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (w[i]) begin
                b = b | MAX_IW'(i);
            end
        end
        return b;
    endfunction

    // Left-rotate by one within the low 'width' bits: MSB-hot wraps to bit0.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] w,
                                               input int unsigned width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i + 1 < width) begin
                r[i+1] = w[i];
            end else if (i + 1 == width) begin
                r[0] = w[i];
            end
        end
        return r;
    endfunction

    // MSB-hot word of the given ring width: the start of every revolution.
    function automatic logic [MAX_W-1:0] ring_seed(input int unsigned width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i + 1 == width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational decode of a ring word into legality flag and binary position.
import ring_pkg::*;

module onehot_decode #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] ring_i,
    output logic             legal_o,
    output logic [IW-1:0]    pos_o
);

    // Legality and position from the zero-extended word.
    always_comb begin
        legal_o = is_onehot(MAX_W'(ring_i));
        pos_o   = IW'(onehot2bin(MAX_W'(ring_i)));
    end

endmodule

// File: rtl/ring_seq_checker.sv
// Receive-side checker for a left-rotating one-hot ring counter: decodes the
// hot position, locks onto the sequence and reports code/sequence errors and laps.
import ring_pkg::*;

module ring_seq_checker #(
    parameter  int unsigned WIDTH      = 4,
    parameter  int unsigned LOCK_STEPS = 2,
    localparam int unsigned IW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             ring_vld,
    output logic [IW-1:0]    idx,
    output logic             idx_vld,
    output logic             locked,
    output logic             code_err,
    output logic             seq_err,
    output logic             lap,
    output logic [7:0]       err_cnt,
    output logic [7:0]       lap_cnt
);

    localparam logic [WIDTH-1:0] RING_SEED    = WIDTH'(ring_seed(WIDTH));
    localparam logic [2:0]       LOCK_STEPS_W = 3'(LOCK_STEPS);

    ring_state_e      state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [2:0]       step_q, step_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             idx_vld_q, idx_vld_d;
    logic             code_err_q, code_err_d;
    logic             seq_err_q, seq_err_d;
    logic             lap_q, lap_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [7:0]       lap_cnt_q, lap_cnt_d;

    logic             legal;
    logic [IW-1:0]    pos;
    logic [WIDTH-1:0] succ;
    logic [2:0]       step_inc;
    logic             err_evt;

    onehot_decode #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_decode (
        .ring_i  (ring_in),
        .legal_o (legal),
        .pos_o   (pos)
    );

    assign succ     = WIDTH'(rotl1(MAX_W'(ring_in), WIDTH));
    assign step_inc = step_q + 3'd1;

    // Next-state, expected word, step counter, pulses and counters.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        step_d     = step_q;
        idx_d      = idx_q;
        idx_vld_d  = 1'b0;
        code_err_d = 1'b0;
        seq_err_d  = 1'b0;
        lap_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        lap_cnt_d  = lap_cnt_q;
        err_evt    = 1'b0;

        if (ring_vld) begin
            if (!legal) begin
                // Illegal code from any state drops back to HUNT; idx holds.
                code_err_d = 1'b1;
                err_evt    = 1'b1;
                state_d    = HUNT;
            end else begin
                idx_vld_d = 1'b1;
                idx_d     = pos;
                exp_d     = succ;
                unique case (state_q)
                    HUNT: begin
                        step_d  = '0;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        if (ring_in == exp_q) begin
                            step_d = step_inc;
                            if (step_inc == LOCK_STEPS_W) begin
                                state_d = LOCK;
                            end
                        end else begin
                            step_d = '0;
                        end
                    end
                    LOCK: begin
                        if (ring_in == exp_q) begin
                            if (ring_in == RING_SEED) begin
                                lap_d     = 1'b1;
                                lap_cnt_d = lap_cnt_q + 8'd1;
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            err_evt   = 1'b1;
                            step_d    = '0;
                            state_d   = TRACK;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end

            if (err_evt && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            exp_q      <= RING_SEED;
            step_q     <= '0;
            idx_q      <= '0;
            idx_vld_q  <= 1'b0;
            code_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
            lap_q      <= 1'b0;
            err_cnt_q  <= '0;
            lap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            idx_vld_q  <= idx_vld_d;
            code_err_q <= code_err_d;
            seq_err_q  <= seq_err_d;
            lap_q      <= lap_d;
            err_cnt_q  <= err_cnt_d;
            lap_cnt_q  <= lap_cnt_d;
        end
    end

    assign idx      = idx_q;
    assign idx_vld  = idx_vld_q;
    assign locked   = (state_q == LOCK);
    assign code_err = code_err_q;
    assign seq_err  = seq_err_q;
    assign lap      = lap_q;
    assign err_cnt  = err_cnt_q;
    assign lap_cnt  = lap_cnt_q;

endmodule

// File: tb/tb_ring_seq_checker.sv
// Directed self-checking bench for ring_seq_checker (WIDTH=4, LOCK_STEPS=2).
module tb_ring_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] ring_in = 4'b0000;
    logic       ring_vld = 1'b0;
    logic [1:0] idx;
    logic       idx_vld, locked, code_err, seq_err, lap;
    logic [7:0] err_cnt, lap_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ring_seq_checker #(
        .WIDTH      (4),
        .LOCK_STEPS (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ring_in  (ring_in),
        .ring_vld (ring_vld),
        .idx      (idx),
        .idx_vld  (idx_vld),
        .locked   (locked),
        .code_err (code_err),
        .seq_err  (seq_err),
        .lap      (lap),
        .err_cnt  (err_cnt),
        .lap_cnt  (lap_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input and sample #1 after the rising edge.
    task automatic step(input logic [3:0] w, input logic v);
        @(negedge clk);
        ring_in  = w;
        ring_vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ring_vld = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [22:0] obs;
        #2;
        rst_n = 1'b0;
        #1;
        obs = {idx, idx_vld, locked, code_err, seq_err, lap, err_cnt, lap_cnt};
        n_checks++;
        if (obs !== 23'd0) $display("FAIL reset_async got=%h exp=0", obs);
        else n_pass++;
        ring_in  = 4'b1000;
        ring_vld = 1'b1;
        @(posedge clk);
        #1;
        obs = {idx, idx_vld, locked, code_err, seq_err, lap, err_cnt, lap_cnt};
        n_checks++;
        if (obs !== 23'd0) $display("FAIL reset_held got=%h exp=0", obs);
        else n_pass++;
        @(negedge clk);
        ring_vld = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_clean();
        logic [3:0] w    [9] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0] e_ix [9] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic       e_lk [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       e_lp [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [6:0] obs, exp;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(w[i], 1'b1);
            obs = {idx, idx_vld, locked, code_err, seq_err, lap};
            exp = {e_ix[i], 1'b1, e_lk[i], 2'b00, e_lp[i]};
            n_checks++;
            if (obs !== exp) $display("FAIL clean[%0d] got=%b exp=%b", i, obs, exp);
            else n_pass++;
        end
        n_checks++;
        if ({lap_cnt, err_cnt} !== {8'd2, 8'd0})
            $display("FAIL clean_cnt lap=%0d err=%0d exp lap=2 err=0", lap_cnt, err_cnt);
        else n_pass++;
    endtask

    // Continues from the locked state left by test_clean (next expected 0001).
    task automatic test_illegal();
        logic [6:0] obs;
        step(4'b0001, 1'b1);
        obs = {idx, idx_vld, locked, code_err, seq_err, lap};
        n_checks++;
        if (obs !== 7'b00_1_1_000) $display("FAIL ill_pre got=%b exp=0011000", obs);
        else n_pass++;
        step(4'b0000, 1'b1);
        obs = {idx, idx_vld, locked, code_err, seq_err, lap};
        n_checks++;
        if (obs !== 7'b00_0_0_100 || err_cnt !== 8'd1)
            $display("FAIL ill_zero got=%b err=%0d exp=0000100 err=1", obs, err_cnt);
        else n_pass++;
        step(4'b1100, 1'b1);
        obs = {idx, idx_vld, locked, code_err, seq_err, lap};
        n_checks++;
        if (obs !== 7'b00_0_0_100 || err_cnt !== 8'd2 || lap_cnt !== 8'd2)
            $display("FAIL ill_multi got=%b err=%0d lap=%0d exp=0000100 err=2 lap=2",
                     obs, err_cnt, lap_cnt);
        else n_pass++;
        step(4'b1100, 1'b0);
        obs = {idx, idx_vld, locked, code_err, seq_err, lap};
        n_checks++;
        if (obs !== 7'b00_0_0_000) $display("FAIL ill_after got=%b exp=0000000", obs);
        else n_pass++;
    endtask

    task automatic test_skip();
        logic [3:0] w    [9] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0100, 4'b1000, 4'b0001};
        logic [6:0] e    [9] = '{7'b11_1_0_000, 7'b00_1_0_000, 7'b01_1_1_000,
                                 7'b10_1_1_000, 7'b11_1_1_001, 7'b00_1_1_000,
                                 7'b10_1_0_010, 7'b11_1_0_000, 7'b00_1_1_000};
        logic [6:0] obs;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(w[i], 1'b1);
            obs = {idx, idx_vld, locked, code_err, seq_err, lap};
            n_checks++;
            if (obs !== e[i]) $display("FAIL skip[%0d] got=%b exp=%b", i, obs, e[i]);
            else n_pass++;
        end
        n_checks++;
        if ({err_cnt, lap_cnt} !== {8'd1, 8'd1})
            $display("FAIL skip_cnt err=%0d lap=%0d exp err=1 lap=1", err_cnt, lap_cnt);
        else n_pass++;
    endtask

    task automatic test_gapped();
        logic [3:0] w    [9] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] junk [9] = '{4'b1111, 4'b0000, 4'b0101, 4'b0010, 4'b1000,
                                 4'b0110, 4'b0001, 4'b1001, 4'b0100};
        logic [1:0] e_ix [9] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic       e_lk [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       e_lp [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [6:0] obs, exp;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(w[i], 1'b1);
            obs = {idx, idx_vld, locked, code_err, seq_err, lap};
            exp = {e_ix[i], 1'b1, e_lk[i], 2'b00, e_lp[i]};
            n_checks++;
            if (obs !== exp) $display("FAIL gap_v[%0d] got=%b exp=%b", i, obs, exp);
            else n_pass++;
            step(junk[i], 1'b0);
            obs = {idx, idx_vld, locked, code_err, seq_err, lap};
            exp = {e_ix[i], 1'b0, e_lk[i], 3'b000};
            n_checks++;
            if (obs !== exp) $display("FAIL gap_idle[%0d] got=%b exp=%b", i, obs, exp);
            else n_pass++;
        end
        n_checks++;
        if ({lap_cnt, err_cnt} !== {8'd2, 8'd0})
            $display("FAIL gap_cnt lap=%0d err=%0d exp lap=2 err=0", lap_cnt, err_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 255; i++) step(4'b0000, 1'b1);
        n_checks++;
        if (err_cnt !== 8'd255) $display("FAIL err_255 got=%0d exp=255", err_cnt);
        else n_pass++;
        for (int i = 0; i < 45; i++) step(4'b0011, 1'b1);
        n_checks++;
        if (err_cnt !== 8'd255 || code_err !== 1'b1)
            $display("FAIL err_sat got=%0d code_err=%b exp=255 1", err_cnt, code_err);
        else n_pass++;
    endtask

    task automatic test_lap_wrap();
        do_reset();
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        for (int k = 0; k < 256; k++) begin
            step(4'b0100, 1'b1);
            step(4'b1000, 1'b1);
            step(4'b0001, 1'b1);
            step(4'b0010, 1'b1);
        end
        n_checks++;
        if (lap_cnt !== 8'd0 || locked !== 1'b1)
            $display("FAIL lap_256 got=%0d locked=%b exp=0 1", lap_cnt, locked);
        else n_pass++;
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1);
        n_checks++;
        if ({lap, lap_cnt, err_cnt} !== {1'b1, 8'd1, 8'd0})
            $display("FAIL lap_257 lap=%b cnt=%0d err=%0d exp 1 1 0", lap, lap_cnt, err_cnt);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [22:0] obs;
        logic [6:0]  o7;
        do_reset();
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1);
        n_checks++;
        if ({locked, lap, lap_cnt} !== {1'b1, 1'b1, 8'd1})
            $display("FAIL ar_pre locked=%b lap=%b cnt=%0d exp 1 1 1", locked, lap, lap_cnt);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        obs = {idx, idx_vld, locked, code_err, seq_err, lap, err_cnt, lap_cnt};
        n_checks++;
        if (obs !== 23'd0) $display("FAIL ar_immediate got=%h exp=0", obs);
        else n_pass++;
        @(negedge clk);
        ring_in  = 4'b0001;
        ring_vld = 1'b1;
        @(negedge clk);
        ring_vld = 1'b0;
        rst_n    = 1'b1;
        step(4'b0010, 1'b1);
        o7 = {idx, idx_vld, locked, code_err, seq_err, lap};
        n_checks++;
        if (o7 !== 7'b01_1_0_000) $display("FAIL ar_hunt got=%b exp=0110000", o7);
        else n_pass++;
        step(4'b0100, 1'b1);
        o7 = {idx, idx_vld, locked, code_err, seq_err, lap};
        n_checks++;
        if (o7 !== 7'b10_1_0_000) $display("FAIL ar_step1 got=%b exp=1010000", o7);
        else n_pass++;
        step(4'b1000, 1'b1);
        o7 = {idx, idx_vld, locked, code_err, seq_err, lap};
        n_checks++;
        if (o7 !== 7'b11_1_1_000 || lap_cnt !== 8'd0)
            $display("FAIL ar_step2 got=%b lap_cnt=%0d exp=1111000 0", o7, lap_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_illegal();
        test_skip();
        test_gapped();
        test_saturation();
        test_lap_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
